// File: rtl/shift_operand_stage.sv
// shift_operand_stage
//   Decode-to-EX boundary for the logical/arithmetic shifter. It resolves
//   rs1/rs2 forwarding, picks and masks the shift amount, and presents
//   {a, n, op, word} to the shifter through a 2-entry skid buffer.
//
// Optional build macro: SHIFT_WORD_OPS_EN
//   Defined   : RV64 *W ops (32-bit operand, 5-bit amount, out_word=1).
//   Undefined : in_word is ignored, out_word is always 0.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   flush                       drop all buffered ops and the op presented this cycle
//   in_valid / in_ready         decode-side handshake
//   in_op, in_word, in_use_imm  op tag, word variant, immediate-amount select
//   in_imm                      immediate shift amount
//   in_rs1/2, in_rs1/2_data     source indices and register-file read data
//   exm_wen/rd/data             EX/MEM forwarding source (highest priority)
//   mwb_wen/rd/data             MEM/WB forwarding source
//   out_valid / out_ready       shifter-side handshake
//   out_a, out_n, out_op        operand, amount and op tag to the shifter
//   out_word                    downstream must sign-extend result bit 31
//
// state | meaning
// EMPTY | nothing buffered, out_valid=0, in_ready=1
// ONE   | output register holds an op, skid empty, in_ready=1
// TWO   | output register and skid both full, in_ready=0

module shift_operand_stage #(
    parameter int XLEN = 64,
    parameter int SHW  = 6,
    parameter int OPW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic            in_word,
    input  logic            in_use_imm,
    input  logic [SHW-1:0]  in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            exm_wen,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wen,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [SHW-1:0]  out_n,
    output logic [OPW-1:0]  out_op,
    output logic            out_word
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [SHW-1:0]  n;
        logic [OPW-1:0]  op;
        logic            word;
    } payload_t;

    state_t   state, state_nxt;
    payload_t res, out_q, skid_q;
    logic     load_out_in, load_out_skid, load_skid;
    logic     in_fire;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [SHW-1:0]  shamt;

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs,
                                            input logic [XLEN-1:0] rf);
        if (rs == 5'd0)                    return '0;
        else if (exm_wen && exm_rd == rs)  return exm_data;
        else if (mwb_wen && mwb_rd == rs)  return mwb_data;
        else                               return rf;
    endfunction

    assign rs1_fwd = fwd(in_rs1, in_rs1_data);
    assign rs2_fwd = fwd(in_rs2, in_rs2_data);
    // Only the low SHW bits of rs2 matter, so amounts >= XLEN wrap here.
    assign shamt   = in_use_imm ? in_imm : rs2_fwd[SHW-1:0];

    // rs2 upper bits are architecturally ignored; in_word is ignored when
    // word ops are compiled out.
    logic unused_bits;
    assign unused_bits = ^{rs2_fwd[XLEN-1:SHW], in_word};

    always_comb begin
        res      = '0;
        res.a    = rs1_fwd;
        res.n    = shamt;
        res.op   = in_op;
        res.word = 1'b0;
        if (in_op == 2'b11) begin
            // reserved tag: pass rs1 through unshifted
            res.n = '0;
        end
`ifdef SHIFT_WORD_OPS_EN
        else if (in_word) begin
            res.word = 1'b1;
            res.n    = {{(SHW-5){1'b0}}, shamt[4:0]};
            if (in_op == 2'b10)
                res.a = {{(XLEN-32){rs1_fwd[31]}}, rs1_fwd[31:0]};
            else
                res.a = {{(XLEN-32){1'b0}}, rs1_fwd[31:0]};
        end
`endif
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    load_out_in = 1'b1;
                    state_nxt   = ONE;
                end
                ONE: begin
                    if (out_ready && in_fire) begin
                        load_out_in = 1'b1;
                    end else if (out_ready) begin
                        state_nxt = EMPTY;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end
                end
                TWO: if (out_ready) begin
                    load_out_skid = 1'b1;
                    state_nxt     = ONE;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_out_in)        out_q  <= res;
            else if (load_out_skid) out_q  <= skid_q;
            if (load_skid)          skid_q <= res;
        end
    end

    assign out_a    = out_q.a;
    assign out_n    = out_q.n;
    assign out_op   = out_q.op;
    assign out_word = out_q.word;

endmodule

// File: tb/tb_shift_operand_stage.sv
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_word, in_use_imm;
    logic [1:0]  in_op, out_op;
    logic [5:0]  in_imm, out_n;
    logic [4:0]  in_rs1, in_rs2, exm_rd, mwb_rd;
    logic [63:0] in_rs1_data, in_rs2_data, exm_data, mwb_data, out_a;
    logic        exm_wen, mwb_wen, out_valid, out_ready, out_word;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_n(out_n), .out_op(out_op), .out_word(out_word)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present an op with rs1 data and immediate amount, no forwarding hit
    task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [5:0] imm);
        in_valid    = 1'b1;
        in_op       = op;
        in_word     = 1'b0;
        in_use_imm  = 1'b1;
        in_imm      = imm;
        in_rs1      = 5'd3;
        in_rs1_data = a;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_use_imm = 1'b0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
        in_rs1_data = '0; in_rs2_data = '0;
        exm_wen = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wen = 1'b0; mwb_rd = '0; mwb_data = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_a", out_a, 64'd0);
        chk("rst_n", {58'd0, out_n}, 64'd0);
        chk("rst_op", {62'd0, out_op}, 64'd0);
        chk("rst_word", {63'd0, out_word}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        // single SRL with immediate
        drive(2'b01, 64'hF000_0000_0000_0000, 6'd4);
        step();
        chk("srl_valid", {63'd0, out_valid}, 64'd1);
        chk("srl_a", out_a, 64'hF000_0000_0000_0000);
        chk("srl_n", {58'd0, out_n}, 64'd4);
        chk("srl_op", {62'd0, out_op}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // forwarding priority on rs1
        drive(2'b00, 64'hCC, 6'd1);
        in_rs1 = 5'd5;
        exm_wen = 1'b1; exm_rd = 5'd5; exm_data = 64'hAA;
        mwb_wen = 1'b1; mwb_rd = 5'd5; mwb_data = 64'hBB;
        step();
        chk("fwd_exm", out_a, 64'hAA);
        exm_wen = 1'b0;
        step();
        chk("fwd_mwb", out_a, 64'hBB);
        mwb_wen = 1'b0;
        step();
        chk("fwd_rf", out_a, 64'hCC);
        exm_wen = 1'b1; mwb_wen = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0; in_rs1 = 5'd0;
        step();
        chk("fwd_x0", out_a, 64'd0);
        exm_wen = 1'b0; mwb_wen = 1'b0;

        // amount from rs2 is masked to 6 bits; rs2 forwarded from MEM/WB
        drive(2'b01, 64'h1234, 6'd0);
        in_use_imm = 1'b0; in_rs2 = 5'd7; in_rs2_data = 64'h47;
        step();
        chk("mask_n", {58'd0, out_n}, 64'h07);
        mwb_wen = 1'b1; mwb_rd = 5'd7; mwb_data = 64'h7F;
        step();
        chk("mask_fwd_n", {58'd0, out_n}, 64'h3F);
        mwb_wen = 1'b0;

        // reserved op tag passes rs1 through with n=0
        drive(2'b11, 64'hDEAD_BEEF, 6'd9);
        step();
        chk("rsv_n", {58'd0, out_n}, 64'd0);
        chk("rsv_a", out_a, 64'hDEAD_BEEF);
        chk("rsv_op", {62'd0, out_op}, 64'd3);

        // word variant
        drive(2'b10, 64'h0000_0000_8000_0010, 6'd0);
        in_word = 1'b1; in_use_imm = 1'b0; in_rs2 = 5'd8; in_rs2_data = 64'h25;
        step();
`ifdef SHIFT_WORD_OPS_EN
        chk("sraw_a", out_a, 64'hFFFF_FFFF_8000_0010);
        chk("sraw_n", {58'd0, out_n}, 64'd5);
        chk("sraw_word", {63'd0, out_word}, 64'd1);
        in_op = 2'b01;
        step();
        chk("srlw_a", out_a, 64'h0000_0000_8000_0010);
`else
        chk("w_off_a", out_a, 64'h0000_0000_8000_0010);
        chk("w_off_n", {58'd0, out_n}, 64'h25);
        chk("w_off_word", {63'd0, out_word}, 64'd0);
`endif
        in_valid = 1'b0; in_word = 1'b0;
        step();
        chk("empty2", {63'd0, out_valid}, 64'd0);

        // backpressure: A, B, C
        out_ready = 1'b0;
        drive(2'b01, 64'hA, 6'd1);
        step();
        chk("bp_a_out", out_a, 64'hA);
        drive(2'b00, 64'hB, 6'd2);
        step();
        chk("bp_two_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_a_held", out_a, 64'hA);
        chk("bp_a_n_held", {58'd0, out_n}, 64'd1);
        drive(2'b10, 64'hC, 6'd3);
        step();
        chk("bp_c_blocked", {63'd0, in_ready}, 64'd0);
        chk("bp_a_still", out_a, 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp_b_out", out_a, 64'hB);
        chk("bp_b_n", {58'd0, out_n}, 64'd2);
        chk("bp_b_op", {62'd0, out_op}, 64'd0);
        step();
        chk("bp_c_out", out_a, 64'hC);
        chk("bp_c_op", {62'd0, out_op}, 64'd2);
        in_valid = 1'b0;
        step();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // flush in TWO with a new op presented
        out_ready = 1'b0;
        drive(2'b01, 64'hD, 6'd4);
        step();
        drive(2'b01, 64'hE, 6'd5);
        step();
        chk("fl_two", {63'd0, in_ready}, 64'd0);
        drive(2'b01, 64'hF, 6'd6);
        flush = 1'b1;
        step();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_no_ghost", {63'd0, out_valid}, 64'd0);

        // async reset while an op is held
        out_ready = 1'b0;
        drive(2'b01, 64'h55, 6'd7);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_a", out_a, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("arst_ready", {63'd0, in_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
